pattern_scan_ctrl: RTL and testbench

- Frame-level controller that sequences the serial 4-bit pattern detector datapath.
- Accepts a start command and byte count, pulls bytes over a valid/ready handshake, and serializes each byte MSB-first into an embedded Mealy detector.
- Counts matches per frame and reports completion.
- Sits between a byte-wide producer (host/FIFO) and the bit-serial detection logic.

---
 rtl/pattern_scan_ctrl_if.sv | 10 +
 rtl/pattern_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_ctrl_if.sv
// Byte stream from a producer (host/FIFO) into pattern_scan_ctrl.
// A byte moves on every rising edge where din_valid and din_ready are both high.
interface pattern_scan_ctrl_if;
    logic       din_valid;
    logic [7:0] din;
    logic       din_ready;

    modport master (output din_valid, output din, input din_ready);
    modport slave  (input din_valid, input din, output din_ready);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Frame controller: pulls bytes, shifts them MSB-first through a Mealy PATTERN detector, counts matches.
// Define PATTERN_NOOVERLAP_EN for non-overlapping detection (history cleared on each match).
module pattern_scan_ctrl #(
    parameter logic [3:0] PATTERN = 4'b1101,
    parameter int         CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           frame_len,
    pattern_scan_ctrl_if.slave   din_if,
    output logic                 busy,
    output logic                 done,
    output logic                 match_pulse,
    output logic [CNT_W-1:0]     match_count,
    output logic                 count_sat,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [7:0]       bytes_left_q, bytes_left_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       hist_q, hist_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             cur_bit;
    logic             match;

    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        hist_d       = hist_q;
        count_d      = count_q;
        sat_d        = sat_q;
        cur_bit      = shift_q[bit_idx_q];
        match        = (state_q == SHIFT) && ({hist_q, cur_bit} == PATTERN);

        case (state_q)
            IDLE: begin
                if (start) begin
                    bytes_left_d = frame_len;
                    count_d      = '0;
                    sat_d        = 1'b0;
                    hist_d       = 3'b000;
                    state_d      = (frame_len != 8'd0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (din_if.din_valid) begin
                    shift_d   = din_if.din;
                    bit_idx_d = 3'd7;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
`ifdef PATTERN_NOOVERLAP_EN
                hist_d = match ? 3'b000 : {hist_q[1:0], cur_bit};
`else
                hist_d = {hist_q[1:0], cur_bit};
`endif
                if (match) begin
                    if (&count_q) sat_d   = 1'b1;
                    else          count_d = count_q + CNT_ONE;
                end
                bit_idx_d = bit_idx_q - 3'd1;
                if (bit_idx_q == 3'd0) begin
                    bytes_left_d = bytes_left_q - 8'd1;
                    state_d      = (bytes_left_q == 8'd1) ? DONE : LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the next-state decode.
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == LOAD);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bytes_left_q <= 8'd0;
            shift_q      <= 8'd0;
            bit_idx_q    <= 3'd0;
            hist_q       <= 3'b000;
            count_q      <= '0;
            sat_q        <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bytes_left_q <= bytes_left_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            hist_q       <= hist_d;
            count_q      <= count_d;
            sat_q        <= sat_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
        end
    end

    assign din_if.din_ready = ready_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign match_pulse      = match;
    assign match_count      = count_q;
    assign count_sat        = sat_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: two instances (CNT_W=16 and CNT_W=2) share stimulus; a monitor
// scores each done pulse against a queue of hand-computed frame results.
module tb_pattern_scan_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] frame_len;
    logic       din_valid;
    logic [7:0] din;

    always #5 clock = ~clock;

    pattern_scan_ctrl_if if0 ();
    pattern_scan_ctrl_if if1 ();
    assign if0.din_valid = din_valid;
    assign if0.din       = din;
    assign if1.din_valid = din_valid;
    assign if1.din       = din;

    logic        busy0, done0, mp0, sat0;
    logic [15:0] cnt0;
    logic [1:0]  st0;
    logic        busy1, done1, mp1, sat1;
    logic [1:0]  cnt1;
    logic [1:0]  st1;

    pattern_scan_ctrl #(.PATTERN(4'b1101), .CNT_W(16)) u_dut0 (
        .clock(clock), .reset(reset), .start(start), .frame_len(frame_len),
        .din_if(if0.slave), .busy(busy0), .done(done0), .match_pulse(mp0),
        .match_count(cnt0), .count_sat(sat0), .state_dbg(st0)
    );

    pattern_scan_ctrl #(.PATTERN(4'b1101), .CNT_W(2)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .frame_len(frame_len),
        .din_if(if1.slave), .busy(busy1), .done(done1), .match_pulse(mp1),
        .match_count(cnt1), .count_sat(sat1), .state_dbg(st1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Entry layout: {pad7, busy_cycles16, ready_cycles8, first_pulse8, pulses8, sat1, count16}
    logic [63:0] exp_q[$];
    logic [63:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [63:0] pack(input int cnt, input int sat, input int pulses,
                                         input int first, input int rdy, input int bcyc);
        return {7'd0, bcyc[15:0], rdy[7:0], first[7:0], pulses[7:0], sat[0], cnt[15:0]};
    endfunction

    logic [1:0]  busy_v, rdy_v, done_v, mp_v, sat_v;
    logic [15:0] cnt_v [2];
    assign busy_v   = {busy1, busy0};
    assign rdy_v    = {if1.din_ready, if0.din_ready};
    assign done_v   = {done1, done0};
    assign mp_v     = {mp1, mp0};
    assign sat_v    = {sat1, sat0};
    assign cnt_v[0] = cnt0;
    assign cnt_v[1] = {14'd0, cnt1};

    int bcnt [2];
    int rcnt [2];
    int pcnt [2];
    int fpos [2];

    // Monitor: accumulate per-frame observations, score them on each done pulse.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                bcnt[k] = 0; rcnt[k] = 0; pcnt[k] = 0; fpos[k] = 0;
            end else begin
                if (busy_v[k]) bcnt[k]++;
                if (rdy_v[k])  rcnt[k]++;
                if (mp_v[k]) begin
                    pcnt[k]++;
                    if (fpos[k] == 0) fpos[k] = bcnt[k];
                end
                if (done_v[k]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dut%0d_unexpected_done: got done=1 expected no done", k);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("dut%0d_count", k),       cnt_v[k],  {16'd0, e[15:0]});
                        check($sformatf("dut%0d_sat", k),         sat_v[k],  {31'd0, e[16]});
                        check($sformatf("dut%0d_pulses", k),      pcnt[k],   {24'd0, e[24:17]});
                        check($sformatf("dut%0d_first_pulse", k), fpos[k],   {24'd0, e[32:25]});
                        check($sformatf("dut%0d_ready_cycles", k), rcnt[k],  {24'd0, e[40:33]});
                        check($sformatf("dut%0d_busy_cycles", k), bcnt[k],   {16'd0, e[56:41]});
                    end
                    bcnt[k] = 0; rcnt[k] = 0; pcnt[k] = 0; fpos[k] = 0;
                end
            end
        end
    end

    // Driver: one frame of up to two distinct bytes (later bytes reuse b1); stall = LOAD cycles
    // with din_valid low before each byte after the first.
    task automatic do_frame(input logic [7:0] len, input logic [7:0] b0, input logic [7:0] b1,
                            input int stall, input bit busy_start,
                            input int c0, input int s0, input int c1, input int s1,
                            input int pulses, input int first);
        int n;
        int bcyc;
        int rdy;
        bcyc = 9 * int'(len) + 1 + ((len > 1) ? stall * (int'(len) - 1) : 0);
        rdy  = int'(len) + ((len > 1) ? stall * (int'(len) - 1) : 0);
        exp_q.push_back(pack(c0, s0, pulses, first, rdy, bcyc));
        exp_q.push_back(pack(c1, s1, pulses, first, rdy, bcyc));

        @(posedge clock); #1;
        start     = 1'b1;
        frame_len = len;
        @(posedge clock); #1;
        if (busy_start) frame_len = 8'd7;
        else begin
            start     = 1'b0;
            frame_len = 8'($urandom_range(1, 255));
        end

        for (int i = 0; i < int'(len); i++) begin
            n = 0;
            @(negedge clock);
            while (!if0.din_ready && n < 200) begin
                @(negedge clock);
                n++;
            end
            if (n >= 200) begin
                fail_now("load_wait");
                return;
            end
            if (i > 0) begin
                repeat (stall) begin
                    check("ready_in_stall", {31'd0, if0.din_ready}, 32'd1);
                    din = 8'($urandom);
                    @(negedge clock);
                end
            end
            din_valid = 1'b1;
            din       = (i == 0) ? b0 : b1;
            @(posedge clock); #1;
            din_valid = 1'b0;
            din       = 8'($urandom);
        end

        if (busy_start) begin
            repeat (4) @(negedge clock);
            start = 1'b0;
        end

        n = 0;
        while ((busy0 || busy1) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) fail_now("frame_end_wait");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        frame_len = 8'd0;
        din_valid = 1'b0;
        din       = 8'd0;
        repeat (3) @(negedge clock);

        check("rst_din_ready",   {31'd0, if0.din_ready}, 32'd0);
        check("rst_busy",        {31'd0, busy0},         32'd0);
        check("rst_done",        {31'd0, done0},         32'd0);
        check("rst_match_pulse", {31'd0, mp0},           32'd0);
        check("rst_match_count", {16'd0, cnt0},          32'd0);
        check("rst_count_sat",   {31'd0, sat0},          32'd0);
        check("rst_state",       {30'd0, st0},           32'd0);
        reset = 1'b1;

        // Basic: 0000_1101 matches on the 8th SHIFT cycle (busy cycle 9).
        do_frame(8'd1, 8'h0D, 8'h00, 0, 1'b0, 1, 0, 1, 0, 1, 9);

        // Overlap: 1101_1011 matches at bits 3 and 6; first pulse on busy cycle 5.
`ifdef PATTERN_NOOVERLAP_EN
        do_frame(8'd1, 8'hDB, 8'h00, 0, 1'b0, 1, 0, 1, 0, 1, 5);
`else
        do_frame(8'd1, 8'hDB, 8'h00, 0, 1'b0, 2, 0, 2, 0, 2, 5);
`endif

        // Cross-byte with a 5-cycle stall: match on 3rd bit of byte 2 (busy cycle 18).
        do_frame(8'd2, 8'h01, 8'hA0, 5, 1'b0, 1, 0, 1, 0, 1, 18);

        // Zero length: straight to DONE, count cleared from the previous frame.
        do_frame(8'd0, 8'h00, 8'h00, 0, 1'b0, 0, 0, 0, 0, 0, 0);

        // Saturation: four matches; the CNT_W=2 instance stops at 3 and flags.
`ifdef PATTERN_NOOVERLAP_EN
        do_frame(8'd2, 8'hDB, 8'hDB, 0, 1'b0, 2, 0, 2, 0, 2, 5);
`else
        do_frame(8'd2, 8'hDB, 8'hDB, 0, 1'b0, 4, 0, 3, 1, 4, 5);
`endif

        // Reset mid-SHIFT of a 3-byte frame.
        @(posedge clock); #1;
        start     = 1'b1;
        frame_len = 8'd3;
        @(posedge clock); #1;
        start     = 1'b0;
        @(negedge clock);
        din_valid = 1'b1;
        din       = 8'hDB;
        @(posedge clock); #1;
        din_valid = 1'b0;
        repeat (6) @(negedge clock);
        check("mid_frame_count", {16'd0, cnt0}, 32'd1);
        check("mid_frame_state", {30'd0, st0},  32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("abort_din_ready",   {31'd0, if0.din_ready}, 32'd0);
        check("abort_busy",        {31'd0, busy0},         32'd0);
        check("abort_done",        {31'd0, done0},         32'd0);
        check("abort_match_pulse", {31'd0, mp0},           32'd0);
        check("abort_match_count", {16'd0, cnt0},          32'd0);
        check("abort_count_sat",   {31'd0, sat0},          32'd0);
        check("abort_state",       {30'd0, st0},           32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        check("abort_no_done_idle", {30'd0, st0}, 32'd0);

        // Start held high while busy must not restart or extend the frame.
        do_frame(8'd1, 8'h0D, 8'h00, 0, 1'b1, 1, 0, 1, 0, 1, 9);

        repeat (3) @(negedge clock);
        check("exp_queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
